matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Sequences one square matrix multiply C = A x B over the shared matrix memories.
//  Sits between control_unit (mult_start/matrix_size -> mult_done) and the A/B/result RAMs.
//  Generates the read addresses, multiply-accumulates the returned elements and writes
//  each finished C element. Runs in the bclk domain with control_unit.
// PARAMETERS
//  N_MAX  4   maximum matrix dimension; the memory row stride is N_MAX (addr = row*N_MAX+col)
//  DW     8   element width of A and B (unsigned)
//  ACC_W  32  accumulator and result width
//  AW     4   address width; must satisfy 2**AW >= N_MAX*N_MAX
// PORTS
//  clk          in   1      clock (bclk)
//  rst          in   1      asynchronous, active-low reset
//  start        in   1      one-cycle pulse from control_unit (mult_start)
//  size         in   4      matrix dimension n; sampled with start
//  abort        in   1      synchronous abort, returns to IDLE
//  a_addr       out  AW     A read address
//  b_addr       out  AW     B read address
//  rd_en        out  1      read strobe to the A and B RAMs
//  a_data       in   DW     A element; valid on the cycle after rd_en
//  b_data       in   DW     B element; valid on the cycle after rd_en
//  result_addr  out  AW     C write address
//  result_data  out  ACC_W  C element
//  result_we    out  1      C write strobe, one cycle per element
//  busy         out  1      high in RUN, DRAIN and WRITE
//  done         out  1      one-cycle pulse when the product is complete (mult_done)
//  err          out  1      one-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset: every output is 0 and state is IDLE, asynchronously while rst is low.
//  States are IDLE, RUN, DRAIN, WRITE and DONE. Indices i (row), j (col) and k are each 0..n-1.
//  IDLE: on start with 1<=size<=N_MAX, latch n and clear i, j, k; go to RUN.
//   If start arrives with size==0 or size>N_MAX, pulse err on the next cycle and stay in IDLE.
//  RUN: rd_en=1, a_addr=i*N_MAX+k, b_addr=k*N_MAX+j, and k increments every cycle.
//   After n cycles (k==n-1 issued), go to DRAIN.
//  Data stage: on the cycle after each rd_en, acc <= (k_d==0 ? 0 : acc) + a_data*b_data.
//   The product is 2*DW bits, zero-extended. The sum wraps modulo 2**ACC_W with no saturation.
//  DRAIN: one cycle, no read. The last product accumulates at the end of this cycle.
//  WRITE: result_we=1, result_addr=i*N_MAX+j, result_data=acc.
//   j increments; when j==n-1, j wraps to 0 and i increments.
//   If (i,j)==(n-1,n-1), go to DONE; otherwise clear k and go to RUN.
//  DONE: done=1 for one cycle, then go to IDLE. result_* hold their last values and result_we=0.
//  Timing: each element takes n+2 cycles.
//   done is asserted in cycle n*n*(n+2)+1 after the edge that samples start.
//  start while busy or in DONE: ignored, with no err.
//  abort: if abort and start are both high in IDLE, abort wins and start is dropped.
//   In any other state, abort returns to IDLE on the next edge. It drops the outputs of the
//   current element: rd_en, result_we and busy go low, and there is no done.
//  Address outputs are 0 whenever rd_en=0. Addresses never exceed n*N_MAX-1.
// TESTING
//  Test 1: n=2, A=[1,2;3,4], B=identity.
//   -> writes 1,2,3,4 to addr 0,1,4,5 in that order; done at cycle 17; busy high for 16 cycles.
//  Test 2: n=4, all elements 255.
//   -> 16 writes of 260100 (0x0003F804); done at cycle 97.
//  Test 3: n=1, A=7, B=9.
//   -> one write of 63 to addr 0 in cycle 3; done in cycle 4.
//  Test 4: start with size=0, then with size=5.
//   -> err pulses each time; busy, rd_en and result_we stay 0.
//  Test 5: start during RUN with a different size, then abort in cycle 10.
//   -> the second start has no effect. After the abort: IDLE, no done, and a new start runs cleanly.
//  Test 6: rst low mid-RUN.
//   -> all outputs go to 0 immediately. After rst releases, no write or done occurs until the next start.

Source files
------------

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Runs one square matrix multiply C = A x B over the shared A/B/result RAMs.
//   For each C element (i,j) it reads row i of A and column j of B over n
//   cycles (RUN). It spends one cycle letting the last product land (DRAIN).
//   It then writes the accumulated sum (WRITE). After the final element it
//   pulses done (DONE).
//
// Ports
//   clk, rst        bclk and asynchronous active-low reset
//   start, size     one-cycle start pulse with the matrix dimension n
//   abort           synchronous abort back to IDLE
//   a_addr, b_addr  A/B read addresses (row*N_MAX+col), 0 when rd_en is low
//   rd_en           read strobe; a_data/b_data carry the element one cycle later
//   a_data, b_data  returned A/B elements
//   result_addr     C write address
//   result_data     C element
//   result_we       C write strobe
//   busy            high in RUN, DRAIN and WRITE
//   done            one-cycle completion pulse
//   err             one-cycle pulse when start carries an illegal size
//   state_dbg       current FSM state, for observation only
//
// Read handshake: the RAMs have no back-pressure. Every cycle with rd_en=1
// yields exactly one A/B element pair on the following cycle. The sequencer
// tags that pair with the k index it was issued with.
module matmul_sequencer #(
  parameter int N_MAX = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       size,
  input  logic             abort,
  output logic [AW-1:0]    a_addr,
  output logic [AW-1:0]    b_addr,
  output logic             rd_en,
  input  logic [DW-1:0]    a_data,
  input  logic [DW-1:0]    b_data,
  output logic [AW-1:0]    result_addr,
  output logic [ACC_W-1:0] result_data,
  output logic             result_we,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [3:0] i_q, i_d;
  logic [3:0] j_q, j_d;
  logic [3:0] k_q, k_d;
  logic       err_d, err_q;

  logic [3:0] last_idx;
  logic       size_ok;

  // Data stage: the element pair arriving this cycle and the k it belongs to.
  logic             rd_q;
  logic [3:0]       kd_q;
  logic [ACC_W-1:0] acc_q;
  logic [2*DW-1:0]  prod;

  // Last written C element.  result_* show these between writes.
  logic [AW-1:0]    res_addr_q;
  logic [ACC_W-1:0] res_data_q;
  logic [AW-1:0]    wr_addr;

  assign last_idx = n_q - 4'd1;
  assign size_ok  = (size != 4'd0) && (32'(size) <= N_MAX);

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          if (size_ok) begin
            n_d     = size;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        k_d = k_q + 4'd1;
        if (k_q == last_idx) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (j_q == last_idx) begin
          j_d = '0;
          i_d = i_q + 4'd1;
        end else begin
          j_d = j_q + 4'd1;
        end
        if ((i_q == last_idx) && (j_q == last_idx)) begin
          state_d = S_DONE;
        end else begin
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // ---------------- Outputs ----------------
  // abort suppresses the current element's strobes in the same cycle.
  // The FSM then lands in IDLE on the next edge.
  assign wr_addr   = AW'(32'(i_q) * N_MAX + 32'(j_q));
  assign rd_en     = (state_q == S_RUN) && !abort;
  assign a_addr    = rd_en ? AW'(32'(i_q) * N_MAX + 32'(k_q)) : '0;
  assign b_addr    = rd_en ? AW'(32'(k_q) * N_MAX + 32'(j_q)) : '0;
  assign result_we = (state_q == S_WRITE) && !abort;
  assign result_addr = result_we ? wr_addr : res_addr_q;
  assign result_data = result_we ? acc_q : res_data_q;
  assign busy      = ((state_q == S_RUN) || (state_q == S_DRAIN) ||
                      (state_q == S_WRITE)) && !abort;
  assign done      = (state_q == S_DONE) && !abort;
  assign err       = err_q;
  assign state_dbg = state_q;

  // ---------------- Multiply-accumulate ----------------
  assign prod = {{DW{1'b0}}, a_data} * {{DW{1'b0}}, b_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= 1'b0;
      kd_q  <= '0;
      acc_q <= '0;
    end else begin
      rd_q <= rd_en;
      if (rd_en) kd_q <= k_q;
      // k==0 starts a fresh element, so no separate clear is needed.
      if (rd_q) acc_q <= ((kd_q == '0) ? '0 : acc_q) + {{(ACC_W-2*DW){1'b0}}, prod};
    end
  end

  // ---------------- Result hold ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_addr_q <= '0;
      res_data_q <= '0;
    end else if (result_we) begin
      res_addr_q <= wr_addr;
      res_data_q <= acc_q;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: RAM model, directed runs, queue scoreboard.
module tb_matmul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  size;
  logic        abort;
  logic [3:0]  a_addr, b_addr;
  logic        rd_en;
  logic [7:0]  a_data, b_data;
  logic [3:0]  result_addr;
  logic [31:0] result_data;
  logic        result_we;
  logic        busy, done, err;
  logic [2:0]  state_dbg;

  matmul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .abort(abort),
    .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
    .a_data(a_data), .b_data(b_data),
    .result_addr(result_addr), .result_data(result_data), .result_we(result_we),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= a_mem[a_addr];
      b_data <= b_mem[b_addr];
    end else begin
      a_data <= 8'h55;
      b_data <= 8'h55;
    end
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int start_cyc = 0;
  int cur_n = 0;
  logic [51:0] exp_q[$];       // {cycle[15:0], addr[3:0], data[31:0]}
  logic [31:0] exp_done_q[$];  // {busy_cycles[15:0], cycle[15:0]}
  logic [15:0] exp_err_q[$];   // cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int rel;
    int seen_start;
    int busy_cnt;
    logic [51:0] e;
    logic [31:0] d;
    logic [15:0] ec;
    bit ok;
    seen_start = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      rel = cyc - start_cyc;
      if (start_cyc != seen_start) begin
        seen_start = start_cyc;
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (rd_en) begin
        ok = (int'(a_addr >> 2) < cur_n) && (int'(a_addr & 4'd3) < cur_n) &&
             (int'(b_addr >> 2) < cur_n) && (int'(b_addr & 4'd3) < cur_n);
        check("addr_range", 64'(ok), 64'(1));
      end else begin
        check("addr_idle_zero", 64'({a_addr, b_addr}), 64'(0));
      end
      if (result_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(result_we), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(result_addr), 64'(e[35:32]));
          check("wr_data", 64'(result_data), 64'(e[31:0]));
          check("wr_cycle", 64'(rel), 64'(e[51:36]));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          d = exp_done_q.pop_front();
          check("done_cycle", 64'(rel), 64'(d[15:0]));
          check("busy_cycles", 64'(busy_cnt), 64'(d[31:16]));
        end
      end
      if (err) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_err", 64'(err), 64'(0));
        end else begin
          ec = exp_err_q.pop_front();
          check("err_cycle", 64'(rel), 64'(ec));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_wr(input int c, input int addr, input logic [31:0] data);
    exp_q.push_back({16'(c), 4'(addr), data});
  endtask

  task automatic push_done(input int busy_cycles, input int c);
    exp_done_q.push_back({16'(busy_cycles), 16'(c)});
  endtask

  task automatic start_run(input logic [3:0] n);
    @(negedge clk);
    start = 1'b1;
    size = n;
    start_cyc = cyc;
    cur_n = int'(n);
    @(negedge clk);
    start = 1'b0;
    size = 4'd0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - start_cyc < r) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((exp_q.size() + exp_done_q.size() + exp_err_q.size() != 0) && t < budget) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("drain_pending", 64'(exp_q.size() + exp_done_q.size() + exp_err_q.size()), 64'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = v;
      b_mem[i] = v;
    end
  endtask

  // A=[1,2;3,4], B=identity; unused locations hold 0xAA
  task automatic load_ident2();
    fill_mem(8'hAA);
    a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[4] = 8'd3; a_mem[5] = 8'd4;
    b_mem[0] = 8'd1; b_mem[1] = 8'd0; b_mem[4] = 8'd0; b_mem[5] = 8'd1;
  endtask

  task automatic run_ident2();
    load_ident2();
    push_wr(4, 0, 32'd1);
    push_wr(8, 1, 32'd2);
    push_wr(12, 4, 32'd3);
    push_wr(16, 5, 32'd4);
    push_done(16, 17);
    start_run(4'd2);
    wait_drain(200);
  endtask

  task automatic run_n1();
    fill_mem(8'hAA);
    a_mem[0] = 8'd7;
    b_mem[0] = 8'd9;
    push_wr(3, 0, 32'd63);
    push_done(3, 4);
    start_run(4'd1);
    wait_drain(100);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_addr"}, 64'(a_addr), 64'(0));
    check({tag, "_b_addr"}, 64'(b_addr), 64'(0));
    check({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    check({tag, "_result_addr"}, 64'(result_addr), 64'(0));
    check({tag, "_result_data"}, 64'(result_data), 64'(0));
    check({tag, "_result_we"}, 64'(result_we), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_state"}, 64'(state_dbg), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    start = 1'b0;
    size = 4'd0;
    abort = 1'b0;
    fill_mem(8'hAA);
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: n=2, A=[1,2;3,4], B=I
    run_ident2();

    // Test 2: n=4, all 255 -> 16 x 260100
    fill_mem(8'd255);
    for (int e = 0; e < 16; e++) push_wr((e + 1) * 6, (e / 4) * 4 + (e % 4), 32'd260100);
    push_done(96, 97);
    start_run(4'd4);
    wait_drain(300);

    // Test 3: n=1
    run_n1();

    // Test 4: illegal sizes 0 and 5
    exp_err_q.push_back(16'd1);
    start_run(4'd0);
    #1;
    check("sz0_busy", 64'(busy), 64'(0));
    check("sz0_rd_en", 64'(rd_en), 64'(0));
    @(negedge clk);
    #1;
    check("sz0_we", 64'(result_we), 64'(0));
    check("sz0_state", 64'(state_dbg), 64'(0));
    exp_err_q.push_back(16'd1);
    start_run(4'd5);
    #1;
    check("sz5_busy", 64'(busy), 64'(0));
    check("sz5_rd_en", 64'(rd_en), 64'(0));
    @(negedge clk);
    #1;
    check("sz5_we", 64'(result_we), 64'(0));
    wait_drain(50);

    // Test 5: start during RUN ignored, abort in cycle 10
    load_ident2();
    push_wr(4, 0, 32'd1);
    push_wr(8, 1, 32'd2);
    start_run(4'd2);
    wait_rel(3);
    start = 1'b1;
    size = 4'd3;
    @(negedge clk);
    start = 1'b0;
    size = 4'd0;
    wait_rel(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_state", 64'(state_dbg), 64'(0));
    check("abort_rd_en", 64'(rd_en), 64'(0));
    repeat (20) @(negedge clk);
    wait_drain(50);
    run_ident2();

    // Test 6: reset mid-RUN
    fill_mem(8'd255);
    start_run(4'd4);
    wait_rel(3);
    #1;
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("post_rst_state", 64'(state_dbg), 64'(0));
    wait_drain(10);
    run_n1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
